// File: rtl/kem_pkg.sv
// kem_pkg: shared KEM types and constants for the SHAKE arbiter slice.
package kem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam logic [2:0] OLT_256       = 3'd0;
    localparam logic       MODE_SHAKE256 = 1'b1;
    localparam int         DIN_W_DEF     = 1024;
endpackage

// File: rtl/shake_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder searching upward from ptr with wrap.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   idx
);
    int j;
    always_comb begin
        win = '0;
        idx = '0;
        j   = 0;
        // Descending offsets so the requester closest to ptr is written last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/shake_arbiter.sv
// shake_arbiter: round-robin sequencer sharing one SHAKE core between NREQ requesters.
// Optional hung-core watchdog enabled by defining SHAKE_ARB_WATCHDOG_EN.
module shake_arbiter
    import kem_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DIN_W   = DIN_W_DEF,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DIN_W-1:0] req_din,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*3-1:0]     req_olt,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       rsp_done,
    output logic [255:0]          rsp_dout,
    output logic                  rsp_err,
    output logic                  shake_start,
    output logic [DIN_W-1:0]      shake_din,
    output logic [LEN_W-1:0]      shake_len,
    output logic                  shake_mode,
    output logic [2:0]            shake_olt,
    input  logic                  shake_done,
    input  logic                  shake_busy,
    input  logic [255:0]          shake_dout
);
    localparam int IW = $clog2(NREQ);
    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win;
    logic            expire;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .idx(win_idx)
    );

`ifdef SHAKE_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd;
    always_ff @(posedge clk)
        wd <= (!rst_n || state != WAIT) ? '0 : wd + 1'b1;
    assign expire = (state == WAIT) && (wd == CW'(TIMEOUT - 1));
`else
    assign expire = TIMEOUT < 0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            grant       <= '0;
            rsp_done    <= '0;
            rsp_dout    <= '0;
            rsp_err     <= 1'b0;
            shake_start <= 1'b0;
            shake_din   <= '0;
            shake_len   <= '0;
            shake_mode  <= 1'b0;
            shake_olt   <= '0;
        end else begin
            rsp_done <= '0;
            case (state)
                IDLE: if (|req) begin
                    grant       <= win;
                    gidx        <= win_idx;
                    shake_din   <= req_din[int'(win_idx)*DIN_W +: DIN_W];
                    shake_len   <= req_len[int'(win_idx)*LEN_W +: LEN_W];
                    shake_mode  <= req_mode[win_idx];
                    shake_olt   <= req_olt[int'(win_idx)*3 +: 3];
                    shake_start <= !shake_busy;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    shake_start <= shake_start ? 1'b0 : !shake_busy;
                    state       <= shake_start ? WAIT : ISSUE;
                end
                // rsp_done is raised here so it is visible the cycle after shake_done.
                WAIT: if (shake_done || expire) begin
                    rsp_done <= grant;
                    rsp_dout <= shake_done ? shake_dout : '0;
                    rsp_err  <= !shake_done;
                    state    <= RESP;
                end
                RESP: begin
                    grant <= '0;
                    ptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
